riscv_top: RTL and testbench

// - Self-contained multi-cycle RV32I-subset processor: core (control FSM, fetch/PC, decode, regfile, ALU) plus unified word-addressed memory.
// - Top of hierarchy: inputs are only clock and reset. Program and data are preloaded into the memory array by the bench.
// - Hierarchy names used by benches: memory.M[], core.RegFile.RFMem[], core.control_fsm.current_state, core.fetch.pc_cur,

---
 rtl/riscv_top.sv | 450 ++++++++++++++++++++++++++++++++++++++++
 tb/tb_riscv_top.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_top.sv
// riscv_top: multi-cycle RV32I-subset core plus unified word memory.
// Build option HALT_ON_ILLEGAL_EN: unsupported opcodes stop the core.

package riscv_pkg;

  typedef enum logic [5:0] {
    FETCH,
    FETCH_WAIT,
    DECODE,
    MEMADR,
    MEMREAD,
    MEMWB,
    MEMWRITE,
    EXECUTER,
    EXECUTEI,
    ALUWB,
    BRANCH,
    HALT
  } state_t;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_SLL,
    ALU_SLT,
    ALU_SLTU,
    ALU_XOR,
    ALU_SRL,
    ALU_SRA,
    ALU_OR,
    ALU_AND
  } alu_op_t;

  typedef enum logic [1:0] {
    AM_ADD,
    AM_SUB,
    AM_REG,
    AM_IMM
  } alu_mode_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef struct packed {
    logic      ir_we;
    logic      pc_inc;
    logic      aluout_we;
    logic      rf_we;
    logic      mem_we;
    logic      addr_alu;
    logic      b_imm;
    logic      branch;
    logic      wb_data;
    alu_mode_t alu_mode;
  } ctrl_t;

endpackage

module riscv_memory #(
  parameter int MEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  output logic [31:0] rdata
);

  localparam int AW = $clog2(MEM_WORDS);

  logic [31:0]   M [MEM_WORDS];
  logic [AW-1:0] idx;
  logic          unused_addr;

  // byte address; high bits beyond the array wrap
  assign idx         = addr[AW+1:2];
  assign unused_addr = ^{addr[31:AW+2], addr[1:0]};

  always_ff @(posedge clk) begin
    if (we) M[idx] <= wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rdata <= '0;
    else        rdata <= M[idx];
  end

endmodule

module riscv_regfile (
  input  logic        clk,
  input  logic        we,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);

  logic [31:0] RFMem [32];

  always_ff @(posedge clk) begin
    if (we && wa != 5'd0) RFMem[wa] <= wd;
  end

  assign rd1 = (ra1 == 5'd0) ? '0 : RFMem[ra1];
  assign rd2 = (ra2 == 5'd0) ? '0 : RFMem[ra2];

endmodule

module riscv_alu
  import riscv_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  alu_op_t     op,
  output logic [31:0] out,
  output logic        zero
);

  always_comb begin
    out = '0;
    unique case (op)
      ALU_ADD:  out = a + b;
      ALU_SUB:  out = a - b;
      ALU_SLL:  out = a << b[4:0];
      ALU_SLT:  out = {31'b0, $signed(a) < $signed(b)};
      ALU_SLTU: out = {31'b0, a < b};
      ALU_XOR:  out = a ^ b;
      ALU_SRL:  out = a >> b[4:0];
      ALU_SRA:  out = $unsigned($signed(a) >>> b[4:0]);
      ALU_OR:   out = a | b;
      ALU_AND:  out = a & b;
      default:  out = '0;
    endcase
  end

  assign zero = (out == '0);

endmodule

module riscv_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pc_inc,
  input  logic        branch_taken,
  input  logic [31:0] imm_ext,
  output logic [31:0] pc_cur
);

  // pc_cur already points past the branch when it resolves
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)            pc_cur <= RESET_PC;
    else if (branch_taken) pc_cur <= pc_cur - 32'd4 + imm_ext;
    else if (pc_inc)       pc_cur <= pc_cur + 32'd4;
  end

endmodule

module riscv_decode
  import riscv_pkg::*;
(
  input  logic [31:0] ir,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic [2:0]  funct3,
  output logic        funct7b5,
  output logic [31:0] imm_ext
);

  logic [6:0] opc;

  assign opc      = ir[6:0];
  assign rs1      = ir[19:15];
  assign rs2      = ir[24:20];
  assign rd       = ir[11:7];
  assign funct3   = ir[14:12];
  assign funct7b5 = ir[30];

  always_comb begin
    imm_ext = {{20{ir[31]}}, ir[31:20]};
    unique case (1'b1)
      (opc == OP_STORE):
        imm_ext = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      (opc == OP_BRANCH):
        imm_ext = {{19{ir[31]}}, ir[31], ir[7],
                   ir[30:25], ir[11:8], 1'b0};
      default: ;
    endcase
  end

endmodule

module riscv_control_fsm
  import riscv_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  output ctrl_t      ctrl
);

  state_t current_state;
  state_t next_state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) current_state <= FETCH;
    else        current_state <= next_state;
  end

  always_comb begin
    next_state = current_state;
    ctrl       = '0;
    unique case (current_state)
      FETCH: next_state = FETCH_WAIT;
      FETCH_WAIT: begin
        ctrl.ir_we  = 1'b1;
        ctrl.pc_inc = 1'b1;
        next_state  = DECODE;
      end
      DECODE: begin
        unique case (1'b1)
          (opcode == OP_LOAD),
          (opcode == OP_STORE):  next_state = MEMADR;
          (opcode == OP_REG):    next_state = EXECUTER;
          (opcode == OP_IMM):    next_state = EXECUTEI;
          (opcode == OP_BRANCH): next_state = BRANCH;
`ifdef HALT_ON_ILLEGAL_EN
          default:               next_state = HALT;
`else
          default:               next_state = FETCH;
`endif
        endcase
      end
      MEMADR: begin
        ctrl.alu_mode  = AM_ADD;
        ctrl.b_imm     = 1'b1;
        ctrl.aluout_we = 1'b1;
        next_state = (opcode == OP_STORE) ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        ctrl.addr_alu = 1'b1;
        next_state    = MEMWB;
      end
      MEMWB: begin
        ctrl.wb_data = 1'b1;
        ctrl.rf_we   = 1'b1;
        next_state   = FETCH;
      end
      MEMWRITE: begin
        ctrl.addr_alu = 1'b1;
        ctrl.mem_we   = 1'b1;
        next_state    = FETCH;
      end
      EXECUTER: begin
        ctrl.alu_mode  = AM_REG;
        ctrl.aluout_we = 1'b1;
        next_state     = ALUWB;
      end
      EXECUTEI: begin
        ctrl.alu_mode  = AM_IMM;
        ctrl.b_imm     = 1'b1;
        ctrl.aluout_we = 1'b1;
        next_state     = ALUWB;
      end
      ALUWB: begin
        ctrl.rf_we = 1'b1;
        next_state = FETCH;
      end
      BRANCH: begin
        ctrl.alu_mode = AM_SUB;
        ctrl.branch   = 1'b1;
        next_state    = FETCH;
      end
      HALT: next_state = HALT;
      default: next_state = FETCH;
    endcase
  end

endmodule

module riscv_core
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] data,
  output logic [31:0] memory__address,
  output logic [31:0] wdata,
  output logic        mem_write
);

  ctrl_t       ctrl;
  logic [31:0] ir;
  logic [31:0] aluout;
  logic [31:0] result;
  logic [6:0]  opcode;
  logic [31:0] pc_cur;
  logic [4:0]  rs1, rs2, rd;
  logic [2:0]  funct3;
  logic        funct7b5;
  logic [31:0] imm_ext;
  logic [31:0] rd1, rd2;
  logic [31:0] alu_b, alu_out;
  logic        alu_zero;
  alu_op_t     alu_op;
  logic        branch_taken;

  assign opcode = ir[6:0];

  riscv_control_fsm control_fsm (
    .clk    (clk),
    .reset  (reset),
    .opcode (opcode),
    .ctrl   (ctrl)
  );

  riscv_fetch #(.RESET_PC(RESET_PC)) fetch (
    .clk          (clk),
    .reset        (reset),
    .pc_inc       (ctrl.pc_inc),
    .branch_taken (branch_taken),
    .imm_ext      (imm_ext),
    .pc_cur       (pc_cur)
  );

  riscv_decode instruction_decode (
    .ir       (ir),
    .rs1      (rs1),
    .rs2      (rs2),
    .rd       (rd),
    .funct3   (funct3),
    .funct7b5 (funct7b5),
    .imm_ext  (imm_ext)
  );

  riscv_regfile RegFile (
    .clk (clk),
    .we  (ctrl.rf_we),
    .ra1 (rs1),
    .ra2 (rs2),
    .wa  (rd),
    .wd  (result),
    .rd1 (rd1),
    .rd2 (rd2)
  );

  assign alu_b = ctrl.b_imm ? imm_ext : rd2;

  // immediate forms have no SUB; bit 30 only selects SRAI there
  always_comb begin
    alu_op = ALU_ADD;
    unique case (ctrl.alu_mode)
      AM_ADD: alu_op = ALU_ADD;
      AM_SUB: alu_op = ALU_SUB;
      default: begin
        unique case (funct3)
          3'b000: alu_op = (ctrl.alu_mode == AM_REG && funct7b5)
                           ? ALU_SUB : ALU_ADD;
          3'b001: alu_op = ALU_SLL;
          3'b010: alu_op = ALU_SLT;
          3'b011: alu_op = ALU_SLTU;
          3'b100: alu_op = ALU_XOR;
          3'b101: alu_op = funct7b5 ? ALU_SRA : ALU_SRL;
          3'b110: alu_op = ALU_OR;
          3'b111: alu_op = ALU_AND;
          default: alu_op = ALU_ADD;
        endcase
      end
    endcase
  end

  riscv_alu alu (
    .a    (rd1),
    .b    (alu_b),
    .op   (alu_op),
    .out  (alu_out),
    .zero (alu_zero)
  );

  always_comb begin
    branch_taken = 1'b0;
    if (ctrl.branch) begin
      unique case (funct3)
        3'b000:  branch_taken = alu_zero;
        3'b001:  branch_taken = !alu_zero;
        default: branch_taken = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ir     <= '0;
      aluout <= '0;
    end else begin
      if (ctrl.ir_we)     ir     <= data;
      if (ctrl.aluout_we) aluout <= alu_out;
    end
  end

  assign result          = ctrl.wb_data ? data : aluout;
  assign memory__address = ctrl.addr_alu ? result : pc_cur;
  assign wdata           = rd2;
  assign mem_write       = ctrl.mem_we;

endmodule

module riscv_top #(
  parameter int          MEM_WORDS = 1024,
  parameter logic [31:0] RESET_PC  = 32'h0
) (
  input logic clk,
  input logic reset
);

  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] data;
  logic        mem_write;

  riscv_core #(.RESET_PC(RESET_PC)) core (
    .clk             (clk),
    .reset           (reset),
    .data            (data),
    .memory__address (addr),
    .wdata           (wdata),
    .mem_write       (mem_write)
  );

  riscv_memory #(.MEM_WORDS(MEM_WORDS)) memory (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .wdata (wdata),
    .we    (mem_write),
    .rdata (data)
  );

endmodule

// File: tb/tb_riscv_top.sv
// tb_riscv_top: directed sequences plus random programs
// scored against an instruction-level model.

module tb_riscv_top;
  import riscv_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_pass = 0;
  int n_chk = 0;

  always #5 clk = ~clk;

  riscv_top #(.MEM_WORDS(1024), .RESET_PC(32'h0)) dut (
    .clk   (clk),
    .reset (reset)
  );

  typedef enum int {
    K_ADD, K_SUB, K_AND, K_OR, K_XOR, K_SLT, K_SLL, K_SRL, K_SRA,
    K_ADDI, K_ANDI, K_ORI, K_XORI, K_SLTI, K_LW, K_SW, K_BEQ, K_BNE
  } kind_t;

  typedef struct {
    kind_t       k;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
  } ins_t;

  ins_t        prog [256];
  logic [31:0] rf_m [32];
  logic [31:0] mem_m [1024];
  logic [31:0] pc_m;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] st();
    return 32'(dut.core.control_fsm.current_state);
  endfunction

  function automatic logic [31:0] pc();
    return dut.core.fetch.pc_cur;
  endfunction

  function automatic logic [31:0] xr(input int i);
    return dut.core.RegFile.RFMem[i];
  endfunction

  function automatic logic [31:0] enc_i(input logic [31:0] imm,
    input logic [4:0] rs1, input logic [2:0] f3,
    input logic [4:0] rd, input logic [6:0] op);
    return {imm[11:0], rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_s(input logic [31:0] imm,
    input logic [4:0] rs2, input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], OP_STORE};
  endfunction

  function automatic logic [31:0] enc_b(input logic [31:0] imm,
    input logic [4:0] rs2, input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11],
            OP_BRANCH};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7,
    input logic [4:0] rs2, input logic [4:0] rs1,
    input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, OP_REG};
  endfunction

  function automatic logic [31:0] encode(input ins_t x);
    case (x.k)
      K_ADD:  return enc_r(7'h00, x.rs2, x.rs1, 3'd0, x.rd);
      K_SUB:  return enc_r(7'h20, x.rs2, x.rs1, 3'd0, x.rd);
      K_AND:  return enc_r(7'h00, x.rs2, x.rs1, 3'd7, x.rd);
      K_OR:   return enc_r(7'h00, x.rs2, x.rs1, 3'd6, x.rd);
      K_XOR:  return enc_r(7'h00, x.rs2, x.rs1, 3'd4, x.rd);
      K_SLT:  return enc_r(7'h00, x.rs2, x.rs1, 3'd2, x.rd);
      K_SLL:  return enc_r(7'h00, x.rs2, x.rs1, 3'd1, x.rd);
      K_SRL:  return enc_r(7'h00, x.rs2, x.rs1, 3'd5, x.rd);
      K_SRA:  return enc_r(7'h20, x.rs2, x.rs1, 3'd5, x.rd);
      K_ADDI: return enc_i(x.imm, x.rs1, 3'd0, x.rd, OP_IMM);
      K_ANDI: return enc_i(x.imm, x.rs1, 3'd7, x.rd, OP_IMM);
      K_ORI:  return enc_i(x.imm, x.rs1, 3'd6, x.rd, OP_IMM);
      K_XORI: return enc_i(x.imm, x.rs1, 3'd4, x.rd, OP_IMM);
      K_SLTI: return enc_i(x.imm, x.rs1, 3'd2, x.rd, OP_IMM);
      K_LW:   return enc_i(x.imm, x.rs1, 3'd2, x.rd, OP_LOAD);
      K_SW:   return enc_s(x.imm, x.rs2, x.rs1);
      K_BEQ:  return enc_b(x.imm, x.rs2, x.rs1, 3'd0);
      default: return enc_b(x.imm, x.rs2, x.rs1, 3'd1);
    endcase
  endfunction

  task automatic gen(output ins_t x);
    x.k   = kind_t'($urandom_range(0, 17));
    x.rd  = 5'($urandom_range(0, 30));
    x.rs1 = 5'($urandom_range(0, 31));
    x.rs2 = 5'($urandom_range(0, 31));
    x.imm = 32'(int'($urandom_range(0, 4095)) - 2048);
    if (x.k == K_LW || x.k == K_SW) begin
      x.rs1 = 5'd31;
      x.imm = 32'(int'($urandom_range(0, 255)) - 128);
    end
    if (x.k == K_BEQ || x.k == K_BNE) begin
      x.imm = 32'(8 + 4 * int'($urandom_range(0, 2)));
      if ($urandom_range(0, 1) == 1) x.rs2 = x.rs1;
    end
  endtask

  // architectural effect of one instruction
  task automatic model_step(output int lat, output bit wr_rf,
                            output bit wr_mem, output int widx);
    ins_t x;
    logic [31:0] a, b, r, ad, nxt;
    bit imm_op;
    x = prog[pc_m[9:2]];
    imm_op = x.k inside {K_ADDI, K_ANDI, K_ORI, K_XORI, K_SLTI,
                         K_LW, K_SW};
    a = rf_m[x.rs1];
    b = imm_op ? x.imm : rf_m[x.rs2];
    r = '0;
    lat = 5;
    wr_rf = 1'b1;
    wr_mem = 1'b0;
    widx = 0;
    nxt = pc_m + 4;
    case (x.k)
      K_ADD, K_ADDI: r = a + b;
      K_SUB:         r = a - b;
      K_AND, K_ANDI: r = a & b;
      K_OR, K_ORI:   r = a | b;
      K_XOR, K_XORI: r = a ^ b;
      K_SLT, K_SLTI: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      K_SLL:         r = a << b[4:0];
      K_SRL:         r = a >> b[4:0];
      K_SRA:         r = 32'($signed(a) >>> b[4:0]);
      K_LW: begin
        ad = a + b;
        r = mem_m[ad[11:2]];
        lat = 6;
      end
      K_SW: begin
        ad = a + b;
        widx = int'(ad[11:2]);
        mem_m[widx] = rf_m[x.rs2];
        wr_mem = 1'b1;
        wr_rf = 1'b0;
      end
      default: begin
        lat = 4;
        wr_rf = 1'b0;
        if ((x.k == K_BEQ) == (a == b)) nxt = pc_m + x.imm;
      end
    endcase
    if (x.rd == 5'd0) wr_rf = 1'b0;
    if (wr_rf) rf_m[x.rd] = r;
    pc_m = nxt;
  endtask

  task automatic run_instr(output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (st() != 32'(FETCH) && cycles < 20);
  endtask

  task automatic enter_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);

    // load sequence: three lw with 0, +4, -8 offsets
    dut.memory.M[0] = 32'h00012083;
    dut.memory.M[1] = 32'h00412083;
    dut.memory.M[2] = 32'hff812083;
    dut.memory.M[40] = 32'hbadab00f;
    dut.memory.M[42] = 32'hdeadbeef;
    dut.memory.M[43] = 32'hcafebabe;
    dut.core.RegFile.RFMem[2] = 32'ha8;
    chk("rst_state", st(), 32'(FETCH));
    chk("rst_pc", pc(), 32'h0);
    reset = 1'b1;
    @(negedge clk);
    chk("fw_state", st(), 32'(FETCH_WAIT));
    @(negedge clk);
    chk("dec_state", st(), 32'(DECODE));
    chk("dec_opcode", 32'(dut.core.opcode), 32'h03);
    chk("dec_rs1", 32'(dut.core.instruction_decode.rs1), 32'd2);
    chk("dec_rs2", 32'(dut.core.instruction_decode.rs2), 32'd0);
    chk("dec_imm", dut.core.instruction_decode.imm_ext, 32'h0);
    @(negedge clk);
    chk("ma_state", st(), 32'(MEMADR));
    chk("ma_a", dut.core.alu.a, 32'ha8);
    chk("ma_b", dut.core.alu.b, 32'h0);
    chk("ma_out", dut.core.alu.out, 32'ha8);
    @(negedge clk);
    chk("mr_state", st(), 32'(MEMREAD));
    chk("mr_addr", dut.core.memory__address, 32'ha8);
    chk("mr_result", dut.core.result, 32'ha8);
    @(negedge clk);
    chk("mwb_state", st(), 32'(MEMWB));
    chk("mwb_data", dut.core.data, 32'hdeadbeef);
    @(negedge clk);
    chk("lw0_fetch", st(), 32'(FETCH));
    @(negedge clk);
    chk("lw0_x1", xr(1), 32'hdeadbeef);
    chk("lw0_pc", pc(), 32'd4);
    @(negedge clk);
    chk("lw4_imm", dut.core.instruction_decode.imm_ext, 32'd4);
    @(negedge clk);
    chk("lw4_out", dut.core.alu.out, 32'hac);
    repeat (4) @(negedge clk);
    chk("lw4_x1", xr(1), 32'hcafebabe);
    chk("lw4_pc", pc(), 32'd8);
    chk("lw4_x2", xr(2), 32'ha8);
    @(negedge clk);
    chk("lwm8_imm", dut.core.instruction_decode.imm_ext, 32'hfffffff8);
    @(negedge clk);
    chk("lwm8_out", dut.core.alu.out, 32'ha0);
    repeat (4) @(negedge clk);
    chk("lwm8_x1", xr(1), 32'hbadab00f);
    chk("lwm8_pc", pc(), 32'd12);

    // addi, sw, beq backwards
    enter_reset();
    dut.memory.M[0] = enc_i(32'd7, 5'd3, 3'd0, 5'd4, OP_IMM);
    dut.memory.M[1] = enc_s(32'd0, 5'd4, 5'd2);
    dut.memory.M[2] = enc_b(32'hfffffff8, 5'd0, 5'd0, 3'd0);
    dut.core.RegFile.RFMem[3] = 32'd5;
    reset = 1'b1;
    run_instr(n);
    chk("addi_lat", 32'(n), 32'd5);
    chk("addi_x4", xr(4), 32'd12);
    run_instr(n);
    chk("sw_lat", 32'(n), 32'd5);
    chk("sw_mem", dut.memory.M[42], 32'd12);
    run_instr(n);
    chk("beq_lat", 32'(n), 32'd4);
    chk("beq_pc", pc(), 32'd0);

    // x0 write, bne not taken, unsupported opcode
    enter_reset();
    dut.memory.M[0] = enc_i(32'd1, 5'd3, 3'd0, 5'd0, OP_IMM);
    dut.memory.M[1] = enc_i(32'hffffffff, 5'd0, 3'd0, 5'd5, OP_IMM);
    dut.memory.M[2] = enc_b(32'hfffffff8, 5'd0, 5'd0, 3'd1);
    dut.memory.M[3] = 32'h0;
    dut.memory.M[4] = enc_i(32'd9, 5'd0, 3'd0, 5'd7, OP_IMM);
    reset = 1'b1;
    run_instr(n);
    run_instr(n);
    chk("x0_read_zero", xr(5), 32'hffffffff);
    run_instr(n);
    chk("bne_pc", pc(), 32'd12);
`ifdef HALT_ON_ILLEGAL_EN
    repeat (8) @(negedge clk);
    chk("ill_state", st(), 32'(HALT));
    chk("ill_pc", pc(), 32'd16);
`else
    run_instr(n);
    chk("ill_lat", 32'(n), 32'd3);
    chk("ill_pc", pc(), 32'd16);
`endif

    // reset while a load is in flight
    enter_reset();
    dut.memory.M[0] = enc_i(32'd0, 5'd2, 3'd2, 5'd6, OP_LOAD);
    dut.core.RegFile.RFMem[6] = 32'h1234;
    reset = 1'b1;
    n = 0;
    while (st() != 32'(MEMREAD) && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("mid_reach", st(), 32'(MEMREAD));
    reset = 1'b0;
    #1;
    chk("mid_state", st(), 32'(FETCH));
    chk("mid_pc", pc(), 32'd0);
    repeat (3) @(negedge clk);
    chk("mid_x6", xr(6), 32'h1234);

    // random program against the instruction-level model
    enter_reset();
    for (int i = 0; i < 256; i++) begin
      gen(prog[i]);
      dut.memory.M[i] = encode(prog[i]);
    end
    for (int i = 0; i < 1024; i++) mem_m[i] = '0;
    for (int i = 544; i < 608; i++) begin
      mem_m[i] = $urandom;
      dut.memory.M[i] = mem_m[i];
    end
    rf_m[0] = '0;
    for (int i = 1; i < 31; i++) begin
      rf_m[i] = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40))
                                            : $urandom;
      dut.core.RegFile.RFMem[i] = rf_m[i];
    end
    rf_m[31] = 32'h900;
    dut.core.RegFile.RFMem[31] = rf_m[31];
    pc_m = '0;
    reset = 1'b1;
    for (int s = 0; s < 60; s++) begin
      int lat, widx;
      bit wrf, wm;
      logic [4:0] rdi;
      rdi = prog[pc_m[9:2]].rd;
      model_step(lat, wrf, wm, widx);
      run_instr(n);
      chk($sformatf("rnd%0d_lat", s), 32'(n), 32'(lat));
      chk($sformatf("rnd%0d_pc", s), pc(), pc_m);
      if (wrf) chk($sformatf("rnd%0d_x%0d", s, rdi), xr(int'(rdi)),
                   rf_m[rdi]);
      if (wm) chk($sformatf("rnd%0d_m%0d", s, widx),
                  dut.memory.M[widx], mem_m[widx]);
    end
    for (int i = 1; i < 32; i++)
      chk($sformatf("end_x%0d", i), xr(i), rf_m[i]);
    for (int i = 544; i < 608; i++)
      chk($sformatf("end_m%0d", i), dut.memory.M[i], mem_m[i]);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
